regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the register file's 4 retirement write ports among 6 completing requesters (functional units / retirement lanes).
- Each cycle it grants up to 4 requesters in round-robin order and never grants two writes to the same architectural register in one cycle.
- Granted writes are registered and presented to the register file write ports one cycle later.

Parameters:
- NUM_REQ, 6, number of requesters.
- NUM_WR, 4, register file write ports.
- DATA_W, 16, register value width.
- REG_AW, 4, register index width (16 registers).
- TAG_W, 4, instruction/owner tag width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- req_valid[0:NUM_REQ-1]  input  1 each  requester has a write pending
- req_reg[0:NUM_REQ-1]  input  REG_AW each  target register
- req_data[0:NUM_REQ-1]  input  DATA_W each  write value
- req_tag[0:NUM_REQ-1]  input  TAG_W each  writing instruction tag
- req_ready[0:NUM_REQ-1]  output  1 each  grant; the write is accepted when valid and ready are both high
- hold  input  1  freeze arbitration (register file unavailable)
- wr_enable[0:NUM_WR-1]  output  1 each  to retirement_write_data_enable
- wr_target_reg[0:NUM_WR-1]  output  REG_AW each  to retirement_target_reg
- wr_data[0:NUM_WR-1]  output  DATA_W each  to retirement_write_data
- wr_writer[0:NUM_WR-1]  output  TAG_W each  to instruction_writer
- busy_grants  output  3  count of grants issued this cycle (0..4), for performance counters

Behaviour:
- Reset (async, rst=1): wr_enable, wr_target_reg, wr_data and wr_writer all 0; rr_ptr=0. Outputs stay 0 while rst is high. Writes accepted in the cycle before reset asserts are dropped.
- State:
  - rr_ptr, range 0..NUM_REQ-1.
  - One registered output slot per write port.
- Arbitration (combinational, each cycle):
  - Scan requesters in circular order rr_ptr, rr_ptr+1, …, wrapping mod NUM_REQ.
  - Grant requester i if all of: req_valid[i]=1; fewer than NUM_WR grants made so far this cycle; req_reg[i] differs from the target of every earlier grant in this scan.
  - A skipped same-register requester keeps req_ready=0 and retries next cycle.
- req_ready[i] = grant[i]. Ready depends on valid; requesters must not make valid depend on ready.
- busy_grants = number of grants this cycle.
- Slot assignment: the k-th grant in scan order goes to write port k. Ports k ≥ grant count get wr_enable=0 next cycle.
- Latency: a grant in cycle N appears on wr_* in cycle N+1 for exactly one cycle. When no grant is made, wr_enable=0; stale wr_target_reg/data/writer values are allowed.
- rr_ptr update:
  - If any grant: rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - Otherwise rr_ptr is unchanged.
- hold=1: all req_ready=0; busy_grants=0; wr_enable <= 0 next cycle; rr_ptr unchanged. Writes already registered before hold rose still present in the cycle hold rises.
- Edge cases:
  - All 6 requesters valid with distinct registers: exactly 4 granted; the remaining 2 are granted first in the next scan.
  - rr_ptr=5: the scan wraps 5, 0, 1, ….
  - Any requester with valid=0 is skipped without consuming a slot.

Decomposition:
- Shared package (regfile_pkg): DATA_W, REG_AW, TAG_W, NUM_REGS=16, NUM_WR=4 constants; write-port struct typedef {enable, target_reg, data, writer}.
- One natural sub-module: rr_multi_grant. Combinational circular scan producing the grant vector, per-grant slot index and last-grant index, with the same-register conflict check.
- Top level holds rr_ptr, the output slot registers and hold handling.

Test Plan:
- Reset: assert rst mid-stream with valid writes pending → wr_enable all 0 immediately; after release rr_ptr=0, so requester 0 is scanned first.
- Six valid requests to r1..r6 with tags 1..6, rr_ptr=0 → cycle N: req_ready=1,1,1,1,0,0 and busy_grants=4; cycle N+1: ports 0..3 carry r1..r4 and tags 1..4; rr_ptr=4; next cycle requesters 4 and 5 are granted on ports 0 and 1.
- Same-register conflict: req0 and req2 both target r7 (data 0xAAAA, 0xBBBB), req1 targets r3, rr_ptr=0 → req0 and req1 granted, req2 stalls; next cycle req2's 0xBBBB written to r7 on port 0.
- Wrap-around: rr_ptr=5, requesters 5, 0 and 1 valid → grant order 5, 0, 1 on ports 0, 1, 2; rr_ptr becomes 2.
- Hold: hold=1 for 3 cycles with 2 valid requests → no req_ready, wr_enable=0 and rr_ptr steady; on hold release both are granted in the same cycle.
- Sparse traffic: only requester 3 valid (r9 = 0x1234, tag 0xC) → port 0 writes r9 = 0x1234, writer 0xC, next cycle; ports 1–3 disabled; rr_ptr=4.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, write-port record and pointer helper for the register file
// write arbiter.
package regfile_pkg;

  localparam int NUM_REQ  = 6;
  localparam int NUM_WR   = 4;
  localparam int DATA_W   = 16;
  localparam int REG_AW   = 4;
  localparam int TAG_W    = 4;
  localparam int NUM_REGS = 16;

  localparam int PTR_W  = 3;
  localparam int SLOT_W = 2;
  localparam int CNT_W  = 3;

  typedef struct packed {
    logic              enable;
    logic [REG_AW-1:0] target_reg;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  writer;
  } wr_port_t;

  // Requester index arithmetic modulo NUM_REQ; both operands are already < NUM_REQ.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                 input logic [PTR_W-1:0] off);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (PTR_W+1)'(NUM_REQ))
      sum = sum - (PTR_W+1)'(NUM_REQ);
    return sum[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side and register-file-side signals of the write arbiter.
interface regfile_write_arbiter_if;
  import regfile_pkg::*;

  logic              req_valid     [NUM_REQ];
  logic [REG_AW-1:0] req_reg       [NUM_REQ];
  logic [DATA_W-1:0] req_data      [NUM_REQ];
  logic [TAG_W-1:0]  req_tag       [NUM_REQ];
  logic              req_ready     [NUM_REQ];
  logic              hold;
  logic              wr_enable     [NUM_WR];
  logic [REG_AW-1:0] wr_target_reg [NUM_WR];
  logic [DATA_W-1:0] wr_data       [NUM_WR];
  logic [TAG_W-1:0]  wr_writer     [NUM_WR];
  logic [CNT_W-1:0]  busy_grants;

  modport master (
    output req_valid, req_reg, req_data, req_tag, hold,
    input  req_ready, wr_enable, wr_target_reg, wr_data, wr_writer, busy_grants
  );

  modport slave (
    input  req_valid, req_reg, req_data, req_tag, hold,
    output req_ready, wr_enable, wr_target_reg, wr_data, wr_writer, busy_grants
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_multi_grant.sv
// Circular multi-grant scan: up to NUM_WR grants per cycle starting at rr_ptr,
// refusing a second write to a register already granted in this scan.
module rr_multi_grant
  import regfile_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic [REG_AW-1:0]  req_reg [NUM_REQ],
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [SLOT_W-1:0]  slot [NUM_REQ],
  output logic [PTR_W-1:0]   last_idx,
  output logic [CNT_W-1:0]   grant_count
);

  logic [PTR_W-1:0]    scan_idx;
  logic [NUM_REGS-1:0] used_regs;

  always_comb begin
    grant       = '0;
    last_idx    = rr_ptr;
    grant_count = '0;
    scan_idx    = rr_ptr;
    used_regs   = '0;
    for (int i = 0; i < NUM_REQ; i++)
      slot[i] = '0;
    for (int s = 0; s < NUM_REQ; s++) begin
      scan_idx = wrap_add(rr_ptr, PTR_W'(s));
      if (valid[scan_idx] && (grant_count < CNT_W'(NUM_WR)) &&
          !used_regs[req_reg[scan_idx]]) begin
        grant[scan_idx]              = 1'b1;
        slot[scan_idx]               = grant_count[SLOT_W-1:0];
        last_idx                     = scan_idx;
        used_regs[req_reg[scan_idx]] = 1'b1;
        grant_count                  = grant_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write ports among the completing requesters; granted
// writes reach the write ports one cycle after the grant.
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);

  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] valid_eff;
  logic [NUM_REQ-1:0] grant;
  logic [SLOT_W-1:0]  slot_idx [NUM_REQ];
  logic [PTR_W-1:0]   last_idx;
  logic [CNT_W-1:0]   grant_count;
  wr_port_t           slots [NUM_WR];

  // Hold masks every request, so no grants and no pointer movement while frozen.
  always_comb begin
    valid_eff = '0;
    for (int i = 0; i < NUM_REQ; i++)
      valid_eff[i] = bus.req_valid[i] && !bus.hold;
  end

  rr_multi_grant u_scan (
    .valid       (valid_eff),
    .req_reg     (bus.req_reg),
    .rr_ptr      (rr_ptr),
    .grant       (grant),
    .slot        (slot_idx),
    .last_idx    (last_idx),
    .grant_count (grant_count)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      bus.req_ready[i] = grant[i];
    bus.busy_grants = grant_count;
    for (int k = 0; k < NUM_WR; k++) begin
      bus.wr_enable[k]     = slots[k].enable;
      bus.wr_target_reg[k] = slots[k].target_reg;
      bus.wr_data[k]       = slots[k].data;
      bus.wr_writer[k]     = slots[k].writer;
    end
  end

  // Payload fields are only refreshed by a grant; unused ports just drop enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      for (int k = 0; k < NUM_WR; k++)
        slots[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++)
        slots[k].enable <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          slots[slot_idx[i]].enable     <= 1'b1;
          slots[slot_idx[i]].target_reg <= bus.req_reg[i];
          slots[slot_idx[i]].data       <= bus.req_data[i];
          slots[slot_idx[i]].writer     <= bus.req_tag[i];
        end
      end
      if (grant_count != '0)
        rr_ptr <= wrap_add(last_idx, PTR_W'(1));
    end
  end

endmodule
